// File: rtl/dtmr_supervisor.sv
// Dynamic-TMR supervisor: turns majority voting on under hazard, debounces replica fault flags,
// pulses resets into faulty replicas, retires repeat offenders and latches a fail-safe condition.
module dtmr_supervisor #(
    parameter int SETTLE_CYC  = 16,
    parameter int FLT_THR     = 4,
    parameter int RST_CYC     = 8,
    parameter int HOLD_CYC    = 64,
    parameter int MAX_STRIKES = 3,
    parameter int CW          = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          risk_i,
    input  logic          force_tmr_i,
    input  logic [2:0]    fault_i,
    output logic          state_o,
    output logic [2:0]    repl_rst_o,
    output logic [2:0]    dead_o,
    output logic          failsafe_o,
    output logic [2:0]    fsm_o,
    output logic [CW-1:0] recov_cnt_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARM      = 3'd1;
    localparam logic [2:0] S_ACTIVE   = 3'd2;
    localparam logic [2:0] S_RECOVER  = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;
    localparam logic [2:0] S_FAILSAFE = 3'd5;

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] THR          = CW'(FLT_THR);
    localparam logic [CW-1:0] STRIKE_LIMIT = CW'(MAX_STRIKES);
    localparam logic [CW-1:0] ONE          = CW'(1);

    function automatic logic [1:0] pop3(input logic [2:0] v);
        return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

    logic [2:0]          fsm_q, fsm_d;
    logic [CW-1:0]       timer_q, timer_d;
    logic [2:0][CW-1:0]  fltCnt_q, fltCnt_d;
    logic [2:0][CW-1:0]  strike_q, strike_d;
    logic [2:0]          replRst_q, replRst_d;
    logic [2:0]          dead_q, dead_d;
    logic                state_q, state_d;
    logic                failsafe_q, failsafe_d;
    logic [CW-1:0]       recovCnt_q, recovCnt_d;

    logic          req;
    logic [2:0]    eff;
    logic [2:0]    confirmed;
    logic [1:0]    nConf, nDead;
    logic [2:0]    nBad;
    logic [1:0]    confIdx;
    logic [CW-1:0] strikeNext;
    logic          monitorNow, monitorNext;

    assign req        = risk_i | force_tmr_i;
    assign eff        = fault_i & ~dead_q;
    assign nConf      = pop3(confirmed);
    assign nDead      = pop3(dead_q);
    assign nBad       = {1'b0, nConf} + {1'b0, nDead};
    assign confIdx    = confirmed[2] ? 2'd2 : (confirmed[1] ? 2'd1 : 2'd0);
    assign strikeNext = strike_q[confIdx] + ONE;

    always_comb begin
        confirmed = '0;
        for (int i = 0; i < 3; i++) begin
            confirmed[i] = (fltCnt_q[i] == THR);
        end
    end

    // A confirmation always outranks request/timer moves, so it is checked first in ACTIVE/HOLD.
    always_comb begin
        fsm_d      = fsm_q;
        timer_d    = '0;
        replRst_d  = '0;
        dead_d     = dead_q;
        strike_d   = strike_q;
        recovCnt_d = recovCnt_q;
        case (fsm_q)
            S_IDLE: begin
                if (req) fsm_d = S_ARM;
            end
            S_ARM: begin
                if (!req)                        fsm_d = S_HOLD;
                else if (timer_q == SETTLE_LAST) fsm_d = S_ACTIVE;
                else                             timer_d = timer_q + ONE;
            end
            S_ACTIVE, S_HOLD: begin
                if (nBad >= 3'd2) begin
                    fsm_d = S_FAILSAFE;
                end else if (nConf == 2'd1) begin
                    fsm_d             = S_RECOVER;
                    strike_d[confIdx] = strikeNext;
                    if (strikeNext >= STRIKE_LIMIT) begin
                        dead_d[confIdx] = 1'b1;
                    end else begin
                        replRst_d[confIdx] = 1'b1;
                        recovCnt_d = (recovCnt_q == '1) ? recovCnt_q : recovCnt_q + ONE;
                    end
                end else if (fsm_q == S_ACTIVE) begin
                    if (!req) fsm_d = S_HOLD;
                end else if (req) begin
                    fsm_d = S_ACTIVE;
                end else if (timer_q == HOLD_LAST) begin
                    fsm_d = S_IDLE;
                end else begin
                    timer_d = timer_q + ONE;
                end
            end
            S_RECOVER: begin
                // An empty pulse register means the target was just retired instead of reset.
                if (replRst_q == 3'b000) begin
                    fsm_d = (nDead >= 2'd2) ? S_FAILSAFE : S_ARM;
                end else if (timer_q == RST_LAST) begin
                    fsm_d = S_ARM;
                end else begin
                    timer_d   = timer_q + ONE;
                    replRst_d = replRst_q;
                end
            end
            S_FAILSAFE: begin
                fsm_d = S_FAILSAFE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    assign monitorNow  = (fsm_q == S_ACTIVE) || (fsm_q == S_HOLD);
    assign monitorNext = (fsm_d == S_ACTIVE) || (fsm_d == S_HOLD);
    assign state_d     = (fsm_d != S_IDLE);
    assign failsafe_d  = (fsm_d == S_FAILSAFE);

    always_comb begin
        fltCnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (monitorNow && monitorNext && eff[i]) begin
                fltCnt_d[i] = (fltCnt_q[i] == THR) ? THR : fltCnt_q[i] + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q      <= S_IDLE;
            timer_q    <= '0;
            fltCnt_q   <= '0;
            strike_q   <= '0;
            replRst_q  <= '0;
            dead_q     <= '0;
            state_q    <= 1'b0;
            failsafe_q <= 1'b0;
            recovCnt_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            timer_q    <= timer_d;
            fltCnt_q   <= fltCnt_d;
            strike_q   <= strike_d;
            replRst_q  <= replRst_d;
            dead_q     <= dead_d;
            state_q    <= state_d;
            failsafe_q <= failsafe_d;
            recovCnt_q <= recovCnt_d;
        end
    end

    assign state_o     = state_q;
    assign repl_rst_o  = replRst_q;
    assign dead_o      = dead_q;
    assign failsafe_o  = failsafe_q;
    assign fsm_o       = fsm_q;
    assign recov_cnt_o = recovCnt_q;

endmodule

// File: tb/tb_dtmr_supervisor.sv
// Bench for dtmr_supervisor: a vector table and directed strike/reset sequences, then random
// traffic, with every cycle also compared against a countdown-style reference model.
module tb_dtmr_supervisor;

    localparam int SETTLE_CYC  = 16;
    localparam int FLT_THR     = 4;
    localparam int RST_CYC     = 8;
    localparam int HOLD_CYC    = 64;
    localparam int MAX_STRIKES = 3;
    localparam int CW          = 8;

    localparam int M_IDLE = 0, M_ARM = 1, M_ACTIVE = 2, M_RECOVER = 3, M_HOLD = 4, M_FAILSAFE = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          risk_i = 1'b0;
    logic          force_tmr_i = 1'b0;
    logic [2:0]    fault_i = 3'b000;
    logic          state_o;
    logic [2:0]    repl_rst_o;
    logic [2:0]    dead_o;
    logic          failsafe_o;
    logic [2:0]    fsm_o;
    logic [CW-1:0] recov_cnt_o;

    int testCount = 0;
    int failCount = 0;
    int cycleNo   = 0;

    always #5 clk = ~clk;

    dtmr_supervisor #(
        .SETTLE_CYC(SETTLE_CYC), .FLT_THR(FLT_THR), .RST_CYC(RST_CYC),
        .HOLD_CYC(HOLD_CYC), .MAX_STRIKES(MAX_STRIKES), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .risk_i(risk_i), .force_tmr_i(force_tmr_i),
        .fault_i(fault_i), .state_o(state_o), .repl_rst_o(repl_rst_o), .dead_o(dead_o),
        .failsafe_o(failsafe_o), .fsm_o(fsm_o), .recov_cnt_o(recov_cnt_o)
    );

    // Reference model: remaining-cycle countdowns and unbounded fault run lengths.
    int       mMode = M_IDLE;
    int       mSettleLeft = 0, mHoldLeft = 0, mPulseLeft = 0, mTarget = 0, mRecov = 0;
    int       mRun[3];
    int       mStrikes[3];
    bit [2:0] mDead = 3'b000;

    task automatic modelEnterArm();
        mMode = M_ARM;
        mSettleLeft = SETTLE_CYC;
    endtask

    task automatic modelStep();
        bit       req;
        bit [2:0] eff;
        int       nConf, who;
        if (!rst_n) begin
            mMode = M_IDLE; mSettleLeft = 0; mHoldLeft = 0; mPulseLeft = 0; mRecov = 0; mDead = 3'b000;
            for (int i = 0; i < 3; i++) begin mRun[i] = 0; mStrikes[i] = 0; end
            return;
        end
        req = risk_i | force_tmr_i;
        eff = fault_i & ~mDead;
        case (mMode)
            M_IDLE: if (req) modelEnterArm();
            M_ARM: begin
                if (!req) begin mMode = M_HOLD; mHoldLeft = HOLD_CYC; end
                else begin
                    mSettleLeft--;
                    if (mSettleLeft == 0) mMode = M_ACTIVE;
                end
            end
            M_ACTIVE, M_HOLD: begin
                nConf = 0; who = 0;
                for (int i = 0; i < 3; i++) if (mRun[i] >= FLT_THR) begin nConf++; who = i; end
                if (nConf + $countones(mDead) >= 2) mMode = M_FAILSAFE;
                else if (nConf == 1) begin
                    mStrikes[who]++;
                    mMode = M_RECOVER;
                    mTarget = who;
                    if (mStrikes[who] >= MAX_STRIKES) begin mDead[who] = 1'b1; mPulseLeft = 0; end
                    else begin
                        mPulseLeft = RST_CYC;
                        if (mRecov < (1 << CW) - 1) mRecov++;
                    end
                end else if (mMode == M_ACTIVE) begin
                    if (!req) begin mMode = M_HOLD; mHoldLeft = HOLD_CYC; end
                end else if (req) mMode = M_ACTIVE;
                else begin
                    mHoldLeft--;
                    if (mHoldLeft == 0) mMode = M_IDLE;
                end
                for (int i = 0; i < 3; i++)
                    mRun[i] = ((mMode == M_ACTIVE || mMode == M_HOLD) && eff[i]) ? mRun[i] + 1 : 0;
            end
            M_RECOVER: begin
                if (mPulseLeft == 0) begin
                    if ($countones(mDead) >= 2) mMode = M_FAILSAFE;
                    else modelEnterArm();
                end else begin
                    mPulseLeft--;
                    if (mPulseLeft == 0) modelEnterArm();
                end
            end
            default: ;
        endcase
    endtask

    task automatic compareModel();
        logic [2:0] eRst;
        logic [18:0] want, got;
        eRst = (mMode == M_RECOVER && mPulseLeft > 0) ? (3'b001 << mTarget) : 3'b000;
        want = {3'(mMode), mMode != M_IDLE, eRst, mDead, mMode == M_FAILSAFE, 8'(mRecov)};
        got  = {fsm_o, state_o, repl_rst_o, dead_o, failsafe_o, recov_cnt_o};
        testCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL model@cycle%0d: got fsm=%0d st=%b rst=%b dead=%b fs=%b rc=%0d, want fsm=%0d st=%b rst=%b dead=%b fs=%b rc=%0d",
                     cycleNo, fsm_o, state_o, repl_rst_o, dead_o, failsafe_o, recov_cnt_o,
                     mMode, mMode != M_IDLE, eRst, mDead, mMode == M_FAILSAFE, mRecov);
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
        cycleNo++;
        compareModel();
    endtask

    task automatic applyStimulus(input logic rstN, input logic risk, input logic frc,
                                 input logic [2:0] flt, input int cycles);
        rst_n = rstN; risk_i = risk; force_tmr_i = frc; fault_i = flt;
        repeat (cycles) tick();
    endtask

    task automatic checkOutput(input string name, input logic [2:0] eFsm, input logic eState,
                               input logic [2:0] eRst, input logic [2:0] eDead, input logic eFs,
                               input logic [7:0] eRecov);
        testCount++;
        if ({fsm_o, state_o, repl_rst_o, dead_o, failsafe_o, recov_cnt_o} !==
            {eFsm, eState, eRst, eDead, eFs, eRecov}) begin
            failCount++;
            $display("[TB] FAIL %s: got fsm=%0d st=%b rst=%b dead=%b fs=%b rc=%0d, want fsm=%0d st=%b rst=%b dead=%b fs=%b rc=%0d",
                     name, fsm_o, state_o, repl_rst_o, dead_o, failsafe_o, recov_cnt_o,
                     eFsm, eState, eRst, eDead, eFs, eRecov);
        end
    endtask

    typedef struct {
        logic       rstN;
        logic       risk;
        logic       frc;
        logic [2:0] fault;
        int         cycles;
        logic [2:0] eFsm;
        logic       eState;
        logic [2:0] eRst;
        logic [2:0] eDead;
        logic       eFs;
        logic [7:0] eRecov;
    } vec_t;

    vec_t vecs[26];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 3'b000,  2, 3'd0, 1'b0, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'b000,  3, 3'd0, 1'b0, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'b000,  1, 3'd1, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'b100,  5, 3'd1, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'b000,  9, 3'd1, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b000,  1, 3'd1, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b000,  1, 3'd2, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b100,  3, 3'd2, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'b000,  1, 3'd2, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'b100,  5, 3'd3, 1'b1, 3'b100, 3'b000, 1'b0, 8'd1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3'b000,  7, 3'd3, 1'b1, 3'b100, 3'b000, 1'b0, 8'd1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 3'b000,  1, 3'd1, 1'b1, 3'b000, 3'b000, 1'b0, 8'd1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 3'b000, 16, 3'd2, 1'b1, 3'b000, 3'b000, 1'b0, 8'd1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 3'b011,  5, 3'd5, 1'b1, 3'b000, 3'b000, 1'b1, 8'd1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 3'b000, 10, 3'd5, 1'b1, 3'b000, 3'b000, 1'b1, 8'd1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 3'b000,  1, 3'd0, 1'b0, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 3'b000, 17, 3'd2, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 3'b000,  1, 3'd4, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 3'b000, 29, 3'd4, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 3'b000,  1, 3'd2, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 3'b000, 64, 3'd4, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 3'b000,  1, 3'd0, 1'b0, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[22] = '{1'b1, 1'b0, 1'b1, 3'b000,  1, 3'd1, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[23] = '{1'b1, 1'b0, 1'b0, 3'b000,  1, 3'd4, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[24] = '{1'b1, 1'b0, 1'b0, 3'b000, 63, 3'd4, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[25] = '{1'b1, 1'b0, 1'b0, 3'b000,  1, 3'd0, 1'b0, 3'b000, 3'b000, 1'b0, 8'd0};

        for (int i = 0; i < 26; i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].risk, vecs[i].frc, vecs[i].fault, vecs[i].cycles);
            checkOutput($sformatf("vec%0d", i), vecs[i].eFsm, vecs[i].eState, vecs[i].eRst,
                        vecs[i].eDead, vecs[i].eFs, vecs[i].eRecov);
        end

        // Replica 2 confirmed three times: two pulses, then retired without a pulse.
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 17);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 5);
            checkOutput($sformatf("strike%0d", k), 3'd3, 1'b1, (k < 2) ? 3'b010 : 3'b000,
                        (k < 2) ? 3'b000 : 3'b010, 1'b0, 8'((k < 2) ? k + 1 : 2));
            applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, (k < 2) ? 24 : 17);
            checkOutput($sformatf("rearmed%0d", k), 3'd2, 1'b1, 3'b000,
                        (k < 2) ? 3'b000 : 3'b010, 1'b0, 8'((k < 2) ? k + 1 : 2));
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 10);
        checkOutput("dead ignored", 3'd2, 1'b1, 3'b000, 3'b010, 1'b0, 8'd2);

        // Reset in the third cycle of a pulse, after two strikes on replica 3.
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 17);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b001, 5);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 24);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b001, 5);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 2);
        checkOutput("mid pulse", 3'd3, 1'b1, 3'b001, 3'b000, 1'b0, 8'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 1);
        checkOutput("reset mid pulse", 3'd0, 1'b0, 3'b000, 3'b000, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 17);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b001, 5);
        checkOutput("post-reset pulse a", 3'd3, 1'b1, 3'b001, 3'b000, 1'b0, 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 24);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b001, 5);
        checkOutput("post-reset pulse b", 3'd3, 1'b1, 3'b001, 3'b000, 1'b0, 8'd2);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 24);

        // Random traffic with slowly changing fault patterns so confirmations actually occur.
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 39) == 0) risk_i = ~risk_i;
            if ($urandom_range(0, 99) == 0) force_tmr_i = ~force_tmr_i;
            if ($urandom_range(0, 9) == 0) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 5)      fault_i = 3'b000;
                else if (r < 8) fault_i = 3'b001 << $urandom_range(0, 2);
                else            fault_i = 3'($urandom_range(0, 7));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
